// File: rtl/mdu_pkg.sv
// Shared types and decode helpers for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  // Encodings equal funct3 of the M-extension.
  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  function automatic logic is_div(input mdu_op_t op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

  function automatic logic is_rem(input mdu_op_t op);
    return op inside {REM, REMU};
  endfunction

  // Multiplies that return the upper half of the product.
  function automatic logic hi_half(input mdu_op_t op);
    return op inside {MULH, MULHSU, MULHU};
  endfunction

  function automatic logic a_signed(input mdu_op_t op);
    return op inside {MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic b_signed(input mdu_op_t op);
    return op inside {MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement: data_o = neg_i ? -data_i : data_i.
module mdu_negate #(
  parameter int unsigned W = 32
) (
  input  logic         neg_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  // Invert-and-increment when negation is requested.
  always_comb begin
    data_o = neg_i ? (~data_i + W'(1)) : data_i;
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle on operand magnitudes, sign fixed at the end.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CNTW = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mdu_state_t          state_q, state_d;
  mdu_op_t             op_q, op_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     mcand_q, mcand_d;
  logic                sign_q, sign_d;
  logic [XLEN-1:0]     result_q, result_d;

  mdu_op_t             op_in;
  logic                sa, sb, ovf;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic [XLEN:0]       mul_sum, div_shift, div_diff;
  logic                div_qbit;
  logic [2*XLEN-1:0]   acc_step, fix_in, fix_out;
  logic [XLEN-1:0]     fix_res;

  assign op_in = mdu_op_t'(funct3);
  assign sa    = a_signed(op_in) & srcA[XLEN-1];
  assign sb    = b_signed(op_in) & srcB[XLEN-1];
  assign ovf   = ((op_in == DIV) || (op_in == REM)) &&
                 (srcA == {1'b1, {(XLEN-1){1'b0}}}) && (srcB == '1);

  // Magnitudes wrap correctly for the most-negative value when read unsigned.
  mdu_negate #(.W(XLEN)) u_mag_a (.neg_i(sa), .data_i(srcA), .data_o(mag_a));
  mdu_negate #(.W(XLEN)) u_mag_b (.neg_i(sb), .data_i(srcB), .data_o(mag_b));

  // One iteration: acc = {partial, multiplier} for multiply,
  // {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, mcand_q};
    // Partial remainder < divisor, so bit XLEN of the difference is the borrow.
    div_qbit  = ~div_diff[XLEN];
    if (is_div(op_q)) begin
      acc_step = {(div_qbit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                  acc_q[XLEN-2:0], div_qbit};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Choose what gets sign-corrected: full product, quotient or remainder.
  always_comb begin
    if (!is_div(op_q)) begin
      fix_in = acc_step;
    end else if (is_rem(op_q)) begin
      fix_in = {{XLEN{1'b0}}, acc_step[2*XLEN-1:XLEN]};
    end else begin
      fix_in = {{XLEN{1'b0}}, acc_step[XLEN-1:0]};
    end
  end

  mdu_negate #(.W(2*XLEN)) u_fix (.neg_i(sign_q), .data_i(fix_in), .data_o(fix_out));

  assign fix_res = hi_half(op_q) ? fix_out[2*XLEN-1:XLEN] : fix_out[XLEN-1:0];

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    sign_d   = sign_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op_in;
          sign_d  = (op_in == REM) ? sa : (sa ^ sb);
          cnt_d   = CNTW'(XLEN);
          state_d = BUSY;
          if (is_div(op_in)) begin
            acc_d   = {{XLEN{1'b0}}, mag_a};
            mcand_d = mag_b;
          end else begin
            acc_d   = {{XLEN{1'b0}}, mag_b};
            mcand_d = mag_a;
          end
          if (is_div(op_in) && (srcB == '0)) begin
            state_d  = DONE;
            result_d = is_rem(op_in) ? srcA : '1;
          end else if (ovf) begin
            state_d  = DONE;
            result_d = (op_in == DIV) ? srcA : '0;
          end
        end
      end
      BUSY: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_d  = DONE;
          result_d = fix_res;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= MUL;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      sign_q   <= sign_d;
      result_q <= result_d;
    end
  end

  assign ready  = (state_q == IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: stimulus pushes expected results and due
// cycles, a negedge monitor pops and compares on every done pulse.
module tb_mdu_iter;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic            ready;
  logic            done;
  logic [XLEN-1:0] result;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  typedef struct {
    logic [31:0] exp;
    int unsigned due;
    logic [2:0]  f3;
  } exp_t;

  exp_t sbq[$];

  mdu_iter #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .srcA   (srcA),
    .srcB   (srcB),
    .ready  (ready),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: RV32M semantics from 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f3)
      3'd0: begin p = ua * ub;           return p[31:0];  end
      3'd1: begin p = sa * sb;           return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub;           return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic logic is_special(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
    return f3[2] && ((b == 32'h0) ||
                     (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Waits (bounded) for ready, issues one op, scrambles inputs afterwards.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       output int unsigned acc);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    while (ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=%b required=1", ready);
      acc = 0;
      return;
    end
    start  = 1'b1;
    funct3 = f3;
    srcA   = a;
    srcB   = b;
    acc    = cyc + 1;
    e.exp  = model(f3, a, b);
    e.due  = acc + (is_special(f3, a, b) ? 0 : XLEN);
    e.f3   = f3;
    sbq.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    funct3 = 3'($urandom);
    srcA   = $urandom;
    srcB   = $urandom;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && done === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 result=%h (cycle %0d)", result, cyc);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("result_f3_%0d", e.f3), result, e.exp);
        chk("done_latency", cyc, e.due);
        chk("ready_low_in_done", {31'h0, ready}, 32'h0);
      end
    end
  end

  initial begin
    int unsigned acc;
    int          w;
    reset  = 1'b1;
    start  = 1'b0;
    funct3 = '0;
    srcA   = '0;
    srcB   = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready",  {31'h0, ready}, 32'h1);
    chk("reset_done",   {31'h0, done},  32'h0);
    chk("reset_result", result,         32'h0);
    reset = 1'b0;

    // Directed cases.
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, acc);
    issue(3'd0, 32'hFFFF_FFFE, 32'd3, acc);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, acc);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, acc);
    issue(3'd5, 32'd100, 32'd7, acc);
    issue(3'd7, 32'd100, 32'd7, acc);
    issue(3'd5, 32'd5, 32'd0, acc);
    issue(3'd7, 32'd5, 32'd0, acc);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, acc);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, acc);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, acc);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, acc);

    // Handshake: starts while busy and in the done cycle are ignored.
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc);
    while (cyc < acc + 4) @(negedge clk);
    start = 1'b1; funct3 = 3'd0; srcA = 32'd9; srcB = 32'd9;
    @(negedge clk);
    start = 1'b0;
    while (cyc < acc + XLEN) @(negedge clk);
    chk("ready_in_done_cycle", {31'h0, ready}, 32'h0);
    start = 1'b1; funct3 = 3'd5; srcA = 32'd50; srcB = 32'd5;
    @(negedge clk);
    start = 1'b0;
    chk("ready_after_done", {31'h0, ready}, 32'h1);
    chk("done_single_pulse", {31'h0, done}, 32'h0);
    repeat (40) @(negedge clk);

    // Reset mid-operation aborts without a done pulse.
    issue(3'd5, 32'd12345, 32'd11, acc);
    while (cyc < acc + 10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready",  {31'h0, ready}, 32'h1);
    chk("abort_done",   {31'h0, done},  32'h0);
    chk("abort_result", result,         32'h0);
    sbq.delete();
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(3'd5, 32'd12345, 32'd11, acc);

    // Randomised operations.
    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick(), acc);
    end

    w = 0;
    while (sbq.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0", sbq.size());
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
